// File: rtl/ball_engine.sv
// ball_engine: Pong ball motion, wall/paddle collision and scoring, advanced by a tick-divided step.
// Optional feature macro BALL_SPEEDUP_EN: each paddle hit trims one clk off the step period.

module ball_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_HALF = 32,
  parameter int PADDLE1_X   = 16,
  parameter int PADDLE2_X   = 624,
  parameter int SERVE_DELAY = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_on,
  input  logic signed [31:0] ticks_per_px,
  input  logic signed [31:0] paddle1_pos,
  input  logic signed [31:0] paddle2_pos,
  output logic signed [31:0] ball_x,
  output logic signed [31:0] ball_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               serving,
  output logic               score1_pulse,
  output logic               score2_pulse
);

  localparam logic [1:0] ST_SERVE  = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_SCORED = 2'd2;

  localparam logic signed [32:0] HALF_POS = 33'(PADDLE_HALF);
  localparam logic signed [32:0] HALF_NEG = -33'(PADDLE_HALF);

  // Difference is taken one bit wider so extreme paddle values cannot wrap into a false hit.
  function automatic logic in_reach(input logic signed [31:0] y, input logic signed [31:0] pad);
    logic signed [32:0] diff;
    diff = 33'(y) - 33'(pad);
    return (diff <= HALF_POS) && (diff >= HALF_NEG);
  endfunction

  logic [1:0]         state_r;
  logic signed [31:0] serve_cnt_r;
  logic [31:0]        tick_cnt_r;
  logic signed [31:0] base_thr_s;
  logic signed [31:0] thr_s;
  logic               step_s;
  logic signed [31:0] nx_x_s;
  logic signed [31:0] nx_y_s;
  logic               nx_dx_s;
  logic               nx_dy_s;
  logic               hit_s;
  logic               score1_s;
  logic               score2_s;

  // Programmed divider clamped to a minimum of one.
  always_comb begin
    if (ticks_per_px < 32'sd1) begin
      base_thr_s = 32'sd1;
    end else begin
      base_thr_s = ticks_per_px;
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [3:0]         hit_cnt_r;
  logic signed [31:0] fast_thr_s;

  // Each recorded hit removes one clk from the step period, never going below one.
  always_comb begin
    fast_thr_s = base_thr_s - $signed({28'd0, hit_cnt_r});
    if (fast_thr_s < 32'sd1) begin
      thr_s = 32'sd1;
    end else begin
      thr_s = fast_thr_s;
    end
  end

  // Saturating hit counter, cleared when the ball goes back to serve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_r <= 4'd0;
    end else if (step_s && (state_r == ST_PLAY)) begin
      if (hit_s && (hit_cnt_r != 4'hF)) begin
        hit_cnt_r <= hit_cnt_r + 4'd1;
      end
    end else if (step_s && (state_r != ST_SERVE)) begin
      hit_cnt_r <= 4'd0;
    end
  end
`else
  assign thr_s = base_thr_s;
`endif

  // A >= compare keeps the divider from running away if the threshold drops below the count.
  assign step_s = game_on && (tick_cnt_r >= $unsigned(thr_s));

  // Tick divider: counts while running, restarts on the step cycle, parks at zero when halted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= 32'd0;
    end else if (!game_on || step_s) begin
      tick_cnt_r <= 32'd0;
    end else begin
      tick_cnt_r <= tick_cnt_r + 32'd1;
    end
  end

  // Next ball position and direction for one PLAY step; x and y are resolved independently.
  always_comb begin
    nx_y_s  = ball_y;
    nx_dy_s = dir_y;
    nx_x_s  = ball_x;
    nx_dx_s = dir_x;
    hit_s   = 1'b0;

    if (!dir_y) begin
      if (ball_y == 32'sd0) begin
        nx_dy_s = 1'b1;
        nx_y_s  = 32'sd1;
      end else begin
        nx_y_s = ball_y - 32'sd1;
      end
    end else begin
      if (ball_y == SCREEN_H) begin
        nx_dy_s = 1'b0;
        nx_y_s  = SCREEN_H - 1;
      end else begin
        nx_y_s = ball_y + 32'sd1;
      end
    end

    if (dir_x) begin
      if ((ball_x == PADDLE2_X) && in_reach(ball_y, paddle2_pos)) begin
        hit_s   = 1'b1;
        nx_dx_s = 1'b0;
        nx_x_s  = PADDLE2_X - 1;
      end else begin
        nx_x_s = ball_x + 32'sd1;
      end
    end else begin
      if ((ball_x == PADDLE1_X) && in_reach(ball_y, paddle1_pos)) begin
        hit_s   = 1'b1;
        nx_dx_s = 1'b1;
        nx_x_s  = PADDLE1_X + 1;
      end else begin
        nx_x_s = ball_x - 32'sd1;
      end
    end

    score1_s = dir_x && !hit_s && (nx_x_s == SCREEN_W - 1);
    score2_s = !dir_x && !hit_s && (nx_x_s == 32'sd0);
  end

  // Game state, ball registers and score pulses; everything advances only on a step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_SERVE;
      serve_cnt_r  <= SERVE_DELAY;
      ball_x       <= SCREEN_W / 2;
      ball_y       <= SCREEN_H / 2;
      dir_x        <= 1'b1;
      dir_y        <= 1'b1;
      serving      <= 1'b1;
      score1_pulse <= 1'b0;
      score2_pulse <= 1'b0;
    end else begin
      score1_pulse <= 1'b0;
      score2_pulse <= 1'b0;
      if (step_s) begin
        case (state_r)
          ST_SERVE: begin
            if (serve_cnt_r > 32'sd1) begin
              serve_cnt_r <= serve_cnt_r - 32'sd1;
            end else begin
              serve_cnt_r <= 32'sd0;
              state_r     <= ST_PLAY;
              serving     <= 1'b0;
            end
          end
          ST_PLAY: begin
            ball_x       <= nx_x_s;
            ball_y       <= nx_y_s;
            dir_x        <= nx_dx_s;
            dir_y        <= nx_dy_s;
            score1_pulse <= score1_s;
            score2_pulse <= score2_s;
            if (score1_s || score2_s) begin
              state_r <= ST_SCORED;
            end
          end
          // dir_x is left as is: the ball just left through the loser's side, so it serves toward them.
          ST_SCORED: begin
            state_r     <= ST_SERVE;
            serve_cnt_r <= SERVE_DELAY;
            ball_x      <= SCREEN_W / 2;
            ball_y      <= SCREEN_H / 2;
            dir_y       <= 1'b1;
            serving     <= 1'b1;
          end
          default: begin
            state_r <= ST_SCORED;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: directed scenarios plus randomized play against a step-level model.
module tb_ball_engine;

  localparam int W = 640, H = 480, HALF = 32, P1 = 16, P2 = 624, SD = 60;

  logic               clk = 1'b0;
  logic               reset;
  logic               game_on;
  logic signed [31:0] ticks_per_px;
  logic signed [31:0] paddle1_pos;
  logic signed [31:0] paddle2_pos;
  logic signed [31:0] ball_x;
  logic signed [31:0] ball_y;
  logic               dir_x, dir_y, serving, score1_pulse, score2_pulse;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  int m_tick, m_x, m_y, m_countdown, m_hits;
  bit m_dx, m_dy, m_serving, m_scored, m_s1, m_s2;

  always #5 clk = ~clk;

  ball_engine dut (
    .clk(clk), .reset(reset), .game_on(game_on), .ticks_per_px(ticks_per_px),
    .paddle1_pos(paddle1_pos), .paddle2_pos(paddle2_pos),
    .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
    .serving(serving), .score1_pulse(score1_pulse), .score2_pulse(score2_pulse)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic m_reset();
    m_tick = 0; m_x = W / 2; m_y = H / 2; m_dx = 1; m_dy = 1;
    m_serving = 1; m_scored = 0; m_countdown = SD; m_hits = 0; m_s1 = 0; m_s2 = 0;
  endtask

  // Reference: one call per clock edge, using the inputs held across that edge.
  task automatic m_clock();
    int thr, pad;
    bit hit;
    m_s1 = 0; m_s2 = 0;
    if (!game_on) begin m_tick = 0; return; end
    thr = (ticks_per_px < 1) ? 1 : ticks_per_px;
`ifdef BALL_SPEEDUP_EN
    thr = (thr - m_hits < 1) ? 1 : thr - m_hits;
`endif
    if (m_tick < thr) begin m_tick++; return; end
    m_tick = 0;
    if (m_serving) begin
      m_countdown--;
      if (m_countdown <= 0) m_serving = 0;
    end else if (m_scored) begin
      m_scored = 0; m_serving = 1; m_countdown = SD;
      m_x = W / 2; m_y = H / 2; m_dy = 1; m_hits = 0;
    end else begin
      pad = m_dx ? paddle2_pos : paddle1_pos;
      hit = (m_x == (m_dx ? P2 : P1)) && (m_y - pad <= HALF) && (pad - m_y <= HALF);
      if (m_dy && m_y == H) begin m_dy = 0; m_y = H - 1; end
      else if (!m_dy && m_y == 0) begin m_dy = 1; m_y = 1; end
      else m_y += m_dy ? 1 : -1;
      if (hit) begin
        m_x = m_dx ? P2 - 1 : P1 + 1;
        m_dx = !m_dx;
        if (m_hits < 15) m_hits++;
      end else begin
        m_x += m_dx ? 1 : -1;
      end
      if (m_dx && m_x == W - 1) begin m_s1 = 1; m_scored = 1; end
      if (!m_dx && m_x == 0) begin m_s2 = 1; m_scored = 1; end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    edge_n++;
    m_clock();
    #1;
  endtask

  task automatic start_run();
    reset = 1'b0;
    @(negedge clk);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; game_on = 1'b0; ticks_per_px = 1; paddle1_pos = 240; paddle2_pos = 240;
    #12;
    m_reset();
    checks++;
    if (ball_x !== 32'sd320) begin errors++; $display("FAIL reset_x: got %0d expected 320", ball_x); end
    checks++;
    if (ball_y !== 32'sd240) begin errors++; $display("FAIL reset_y: got %0d expected 240", ball_y); end
    checks++;
    if ({dir_x, dir_y, serving, score1_pulse, score2_pulse} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_flags: got %b%b%b%b%b expected 11100", dir_x, dir_y, serving, score1_pulse, score2_pulse);
    end
    game_on = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ball_x, ball_y, serving} !== {32'sd320, 32'sd240, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold: got x=%0d y=%0d srv=%b expected x=320 y=240 srv=1", ball_x, ball_y, serving);
    end
  endtask

  task automatic test_serve_walls_hit();
    ticks_per_px = 1; game_on = 1'b1; paddle1_pos = 240; paddle2_pos = 416;
    start_run();
    for (int i = 0; i < 740; i++) begin
      cycle();
      checks++;
      if ({ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse} !==
          {m_x, m_y, m_dx, m_dy, m_serving, m_s1, m_s2}) begin
        errors++;
        $display("FAIL walls_model edge %0d: got x=%0d y=%0d flags=%b%b%b%b%b expected x=%0d y=%0d flags=%b%b%b%b%b",
                 edge_n, ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse,
                 m_x, m_y, m_dx, m_dy, m_serving, m_s1, m_s2);
      end
      if (edge_n == 119) begin
        checks++;
        if (serving !== 1'b1) begin errors++; $display("FAIL serve_hold: got serving=%b expected 1", serving); end
      end
      if (edge_n == 121) begin
        checks++;
        if ({ball_x, ball_y} !== {32'sd320, 32'sd240}) begin
          errors++; $display("FAIL serve_still: got (%0d,%0d) expected (320,240)", ball_x, ball_y);
        end
      end
      if (edge_n == 122) begin
        checks++;
        if ({ball_x, ball_y} !== {32'sd321, 32'sd241}) begin
          errors++; $display("FAIL first_move: got (%0d,%0d) expected (321,241)", ball_x, ball_y);
        end
      end
      if (edge_n == 600) begin
        checks++;
        if (ball_y !== 32'sd480) begin errors++; $display("FAIL bottom_reach: got y=%0d expected 480", ball_y); end
      end
      if (edge_n == 602) begin
        checks++;
        if ({ball_y, dir_y} !== {32'sd479, 1'b0}) begin
          errors++; $display("FAIL bottom_bounce: got y=%0d dy=%b expected y=479 dy=0", ball_y, dir_y);
        end
      end
      if (edge_n == 728) begin
        checks++;
        if ({ball_x, ball_y} !== {32'sd624, 32'sd416}) begin
          errors++; $display("FAIL at_paddle2: got (%0d,%0d) expected (624,416)", ball_x, ball_y);
        end
      end
      if (edge_n == 730) begin
        checks++;
        if ({ball_x, dir_x} !== {32'sd623, 1'b0}) begin
          errors++; $display("FAIL paddle2_hit: got x=%0d dx=%b expected x=623 dx=0", ball_x, dir_x);
        end
      end
    end
  endtask

  task automatic test_miss_score();
    ticks_per_px = 1; game_on = 1'b1; paddle1_pos = 240; paddle2_pos = 100;
    start_run();
    for (int i = 0; i < 765; i++) begin
      cycle();
      checks++;
      if ({ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse} !==
          {m_x, m_y, m_dx, m_dy, m_serving, m_s1, m_s2}) begin
        errors++;
        $display("FAIL miss_model edge %0d: got x=%0d y=%0d flags=%b%b%b%b%b expected x=%0d y=%0d flags=%b%b%b%b%b",
                 edge_n, ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse,
                 m_x, m_y, m_dx, m_dy, m_serving, m_s1, m_s2);
      end
      if (edge_n == 730) begin
        checks++;
        if (ball_x !== 32'sd625) begin errors++; $display("FAIL paddle2_miss: got x=%0d expected 625", ball_x); end
      end
      if (edge_n == 758) begin
        checks++;
        if ({ball_x, score1_pulse, score2_pulse} !== {32'sd639, 1'b1, 1'b0}) begin
          errors++; $display("FAIL score1_edge: got x=%0d s1=%b s2=%b expected x=639 s1=1 s2=0", ball_x, score1_pulse, score2_pulse);
        end
      end
      if (edge_n == 759) begin
        checks++;
        if ({ball_x, score1_pulse, serving} !== {32'sd639, 1'b0, 1'b0}) begin
          errors++; $display("FAIL score1_width: got x=%0d s1=%b srv=%b expected x=639 s1=0 srv=0", ball_x, score1_pulse, serving);
        end
      end
      if (edge_n == 760) begin
        checks++;
        if ({ball_x, ball_y, dir_x, dir_y, serving} !== {32'sd320, 32'sd240, 1'b1, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL reserve: got (%0d,%0d) dx=%b dy=%b srv=%b expected (320,240) dx=1 dy=1 srv=1",
                   ball_x, ball_y, dir_x, dir_y, serving);
        end
      end
    end
  endtask

  task automatic test_reset_mid_play();
    ticks_per_px = 1; game_on = 1'b1; paddle1_pos = 240; paddle2_pos = 100;
    start_run();
    repeat (758) cycle();
    checks++;
    if (score1_pulse !== 1'b1) begin errors++; $display("FAIL inflight_pulse: got s1=%b expected 1", score1_pulse); end
    #2 reset = 1'b0;
    #1;
    m_reset();
    checks++;
    if ({ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse} !==
        {32'sd320, 32'sd240, 5'b11100}) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d flags=%b%b%b%b%b expected x=320 y=240 flags=11100",
               ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse);
    end
  endtask

  task automatic test_game_on();
    ticks_per_px = 1; game_on = 1'b1; paddle1_pos = 240; paddle2_pos = 240;
    start_run();
    for (int i = 0; i < 260; i++) begin
      cycle();
      checks++;
      if ({ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse} !==
          {m_x, m_y, m_dx, m_dy, m_serving, m_s1, m_s2}) begin
        errors++;
        $display("FAIL gate_model edge %0d: got x=%0d y=%0d flags=%b%b%b%b%b expected x=%0d y=%0d flags=%b%b%b%b%b",
                 edge_n, ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse,
                 m_x, m_y, m_dx, m_dy, m_serving, m_s1, m_s2);
      end
      if (edge_n == 149 || edge_n == 150) begin
        checks++;
        if (serving !== (edge_n == 149)) begin
          errors++; $display("FAIL serve_freeze edge %0d: got serving=%b expected %b", edge_n, serving, edge_n == 149);
        end
      end
      if (edge_n >= 200 && edge_n <= 251) begin
        checks++;
        if ({ball_x, ball_y} !== {32'sd345, 32'sd265}) begin
          errors++; $display("FAIL play_freeze edge %0d: got (%0d,%0d) expected (345,265)", edge_n, ball_x, ball_y);
        end
      end
      if (edge_n == 252) begin
        checks++;
        if ({ball_x, ball_y} !== {32'sd346, 32'sd266}) begin
          errors++; $display("FAIL resume: got (%0d,%0d) expected (346,266)", ball_x, ball_y);
        end
      end
      if (edge_n == 50 || edge_n == 200) game_on = 1'b0;
      if (edge_n == 80 || edge_n == 250) game_on = 1'b1;
    end
  endtask

  task automatic test_speedup();
    int last_edge, prev_x, want;
    ticks_per_px = 3; game_on = 1'b1; paddle1_pos = 240; paddle2_pos = 240;
    start_run();
    last_edge = 0;
    prev_x = W / 2;
`ifdef BALL_SPEEDUP_EN
    want = 3;
`else
    want = 4;
`endif
    for (int i = 0; i < 1700; i++) begin
      cycle();
      checks++;
      if ({ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse} !==
          {m_x, m_y, m_dx, m_dy, m_serving, m_s1, m_s2}) begin
        errors++;
        $display("FAIL speed_model edge %0d: got x=%0d y=%0d flags=%b%b%b%b%b expected x=%0d y=%0d flags=%b%b%b%b%b",
                 edge_n, ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse,
                 m_x, m_y, m_dx, m_dy, m_serving, m_s1, m_s2);
      end
      if (ball_x != prev_x) begin
        if (last_edge > 0 && dir_x && ball_x > 321) begin
          checks++;
          if (edge_n - last_edge != 4) begin
            errors++; $display("FAIL period_before_hit x=%0d: got %0d clks expected 4", ball_x, edge_n - last_edge);
          end
        end
        if (!dir_x && ball_x < 623) begin
          checks++;
          if (edge_n - last_edge != want) begin
            errors++; $display("FAIL period_after_hit x=%0d: got %0d clks expected %0d", ball_x, edge_n - last_edge, want);
          end
        end
        last_edge = edge_n;
        prev_x = ball_x;
      end
      paddle2_pos = m_y;
    end
  endtask

  task automatic test_random_play();
    int p;
    ticks_per_px = 1; game_on = 1'b1; paddle1_pos = 240; paddle2_pos = 240;
    start_run();
    for (int i = 0; i < 12000; i++) begin
      cycle();
      checks++;
      if ({ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse} !==
          {m_x, m_y, m_dx, m_dy, m_serving, m_s1, m_s2}) begin
        errors++;
        $display("FAIL random_model edge %0d: got x=%0d y=%0d flags=%b%b%b%b%b expected x=%0d y=%0d flags=%b%b%b%b%b",
                 edge_n, ball_x, ball_y, dir_x, dir_y, serving, score1_pulse, score2_pulse,
                 m_x, m_y, m_dx, m_dy, m_serving, m_s1, m_s2);
      end
      if (game_on && $urandom_range(0, 199) == 0) begin
        game_on = 1'b0;
        ticks_per_px = $signed(32'($urandom_range(0, 4))) - 32'sd1;
      end else if (!game_on && $urandom_range(0, 3) == 0) begin
        game_on = 1'b1;
      end
      p = $urandom_range(0, 1) ? m_y + int'($urandom_range(0, 80)) - 40 : int'($urandom_range(0, 480));
      if (p < 0) p = 0;
      if (p > H) p = H;
      paddle1_pos = p;
      p = $urandom_range(0, 1) ? m_y + int'($urandom_range(0, 80)) - 40 : int'($urandom_range(0, 480));
      if (p < 0) p = 0;
      if (p > H) p = H;
      paddle2_pos = p;
    end
  endtask

  initial begin
    test_reset();
    test_serve_walls_hit();
    test_miss_score();
    test_reset_mid_play();
    test_game_on();
    test_speedup();
    test_random_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
